// File: rtl/game_pkg.sv
// Shared types, LFSR constants and tile-to-pixel mapping for the board-race turn sequencer.
package game_pkg;

    typedef logic [3:0] tile_idx_t;
    typedef logic [2:0] die_t;

    typedef enum logic [2:0] {
        S_IDLE,
        S_READY,
        S_ROLL,
        S_ISSUE,
        S_WAIT,
        S_CHECK,
        S_OVER
    } seq_state_t;

    localparam logic [7:0] LFSR_SEED = 8'hA5;
    // Taps for x^8+x^6+x^5+x^4+1 on a left-shifting register (bits 7,5,4,3).
    localparam logic [7:0] LFSR_TAPS = 8'hB8;

    function automatic logic [9:0] tile_to_x(input tile_idx_t tile, input int x_origin, input int tile_w);
        int x;
        x = x_origin + int'(tile) * tile_w;
        return x[9:0];
    endfunction

endpackage

// File: rtl/dice_lfsr.sv
// Free-running 8-bit Fibonacci LFSR folded onto a 1..6 die value; steps every cycle, die is combinational from the current state.
module dice_lfsr
    import game_pkg::*;
(
    input  logic clk,
    input  logic rst_n,
    output die_t die
);

    logic [7:0] lfsr_q;
    logic [7:0] lfsr_d;

    always_comb begin
        lfsr_d = {lfsr_q[6:0], ^(lfsr_q & LFSR_TAPS)};
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            lfsr_q <= LFSR_SEED;
        end else begin
            lfsr_q <= lfsr_d;
        end
    end

    // Low three bits span 0..7; values 6 and 7 wrap back onto 1 and 2.
    always_comb begin
        if (lfsr_q[2:0] < 3'd6) begin
            die = lfsr_q[2:0] + 3'd1;
        end else begin
            die = lfsr_q[2:0] - 3'd5;
        end
    end

endmodule

// File: rtl/turn_sequencer.sv
// Two-player turn controller: roll_req -> pos_valid two cycles later, then holds in WAIT until turn_done.
// Optional TURN_TIMEOUT_EN adds a WAIT watchdog that raises sticky timeout_err and forces the turn to complete.
module turn_sequencer
    import game_pkg::*;
#(
    parameter int X_ORIGIN    = 32,
    parameter int TILE_W      = 64,
    parameter int NUM_TILES   = 9,
    parameter int TIMEOUT_CYC = 50_000_000
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       start,
    input  logic       roll_req,
    input  logic       dice_override_en,
    input  logic [2:0] dice_override,
    input  logic       turn_done,
    output logic [9:0] player1_pos_x,
    output logic [9:0] player2_pos_x,
    output logic       pos_valid,
    output logic       active_player,
    output logic [2:0] dice_val,
    output logic       busy,
    output logic       game_over,
    output logic       winner,
    output logic       timeout_err
);

    localparam tile_idx_t  LAST_TILE = tile_idx_t'(NUM_TILES - 1);
    localparam logic [9:0] X0        = 10'(X_ORIGIN);

    seq_state_t state_q, state_d;
    tile_idx_t  tile1_q, tile1_d, tile2_q, tile2_d;
    logic [9:0] p1x_q, p1x_d, p2x_q, p2x_d;
    logic       pos_valid_q, pos_valid_d;
    logic       active_q, active_d;
    die_t       dice_q, dice_d;
    logic       busy_q, busy_d;
    logic       game_over_q, game_over_d;
    logic       winner_q, winner_d;
    logic       timeout_err_q, timeout_err_d;

    die_t       lfsr_die;
    die_t       roll_die;
    tile_idx_t  cur_tile;
    tile_idx_t  new_tile;
    logic [4:0] tile_sum;
    logic       timeout_hit;

    dice_lfsr u_dice (
        .clk   (clk),
        .rst_n (rst_n),
        .die   (lfsr_die)
    );

    always_comb begin
        if (dice_override_en) begin
            roll_die = (dice_override == 3'd0 || dice_override == 3'd7) ? 3'd1 : dice_override;
        end else begin
            roll_die = lfsr_die;
        end
        cur_tile = active_q ? tile2_q : tile1_q;
        tile_sum = 5'(cur_tile) + 5'(roll_die);
        new_tile = (tile_sum > 5'(LAST_TILE)) ? LAST_TILE : tile_sum[3:0];
    end

`ifdef TURN_TIMEOUT_EN
    localparam int CW = $clog2(TIMEOUT_CYC + 1);
    logic [CW-1:0] wait_cnt_q, wait_cnt_d;

    // Counter sits at zero outside WAIT, so every WAIT visit starts fresh.
    always_comb begin
        wait_cnt_d  = (state_q == S_WAIT) ? wait_cnt_q + CW'(1) : '0;
        timeout_hit = (state_q == S_WAIT) && !turn_done && (wait_cnt_q == CW'(TIMEOUT_CYC - 1));
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wait_cnt_q <= '0;
        end else begin
            wait_cnt_q <= wait_cnt_d;
        end
    end
`else
    always_comb begin
        timeout_hit = 1'b0;
    end
`endif

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q       <= S_IDLE;
            tile1_q       <= '0;
            tile2_q       <= '0;
            p1x_q         <= X0;
            p2x_q         <= X0;
            pos_valid_q   <= 1'b0;
            active_q      <= 1'b0;
            dice_q        <= '0;
            busy_q        <= 1'b0;
            game_over_q   <= 1'b0;
            winner_q      <= 1'b0;
            timeout_err_q <= 1'b0;
        end else begin
            state_q       <= state_d;
            tile1_q       <= tile1_d;
            tile2_q       <= tile2_d;
            p1x_q         <= p1x_d;
            p2x_q         <= p2x_d;
            pos_valid_q   <= pos_valid_d;
            active_q      <= active_d;
            dice_q        <= dice_d;
            busy_q        <= busy_d;
            game_over_q   <= game_over_d;
            winner_q      <= winner_d;
            timeout_err_q <= timeout_err_d;
        end
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            S_IDLE:  if (start)                    state_d = S_READY;
            S_READY: if (roll_req)                 state_d = S_ROLL;
            S_ROLL:                                state_d = S_ISSUE;
            S_ISSUE:                               state_d = S_WAIT;
            S_WAIT:  if (turn_done || timeout_hit) state_d = S_CHECK;
            S_CHECK:                               state_d = (cur_tile == LAST_TILE) ? S_OVER : S_READY;
            S_OVER:  if (start)                    state_d = S_READY;
            default:                               state_d = S_IDLE;
        endcase
    end

    // Outputs are registered, so they are computed one cycle ahead from the transition being taken.
    always_comb begin
        tile1_d       = tile1_q;
        tile2_d       = tile2_q;
        p1x_d         = p1x_q;
        p2x_d         = p2x_q;
        pos_valid_d   = 1'b0;
        active_d      = active_q;
        dice_d        = dice_q;
        winner_d      = winner_q;
        timeout_err_d = timeout_err_q | timeout_hit;
        busy_d        = state_d inside {S_ROLL, S_ISSUE, S_WAIT, S_CHECK};
        game_over_d   = (state_d == S_OVER);
        case (state_q)
            S_ROLL: begin
                dice_d      = roll_die;
                pos_valid_d = 1'b1;
                if (active_q) begin
                    tile2_d = new_tile;
                    p2x_d   = tile_to_x(new_tile, X_ORIGIN, TILE_W);
                end else begin
                    tile1_d = new_tile;
                    p1x_d   = tile_to_x(new_tile, X_ORIGIN, TILE_W);
                end
            end
            S_CHECK: begin
                if (state_d == S_OVER) begin
                    winner_d = active_q;
                end else begin
                    active_d = ~active_q;
                end
            end
            S_OVER: begin
                if (start) begin
                    tile1_d     = '0;
                    tile2_d     = '0;
                    p1x_d       = X0;
                    p2x_d       = X0;
                    active_d    = 1'b0;
                    pos_valid_d = 1'b1;
                end
            end
            default: ;
        endcase
    end

    assign player1_pos_x = p1x_q;
    assign player2_pos_x = p2x_q;
    assign pos_valid     = pos_valid_q;
    assign active_player = active_q;
    assign dice_val      = dice_q;
    assign busy          = busy_q;
    assign game_over     = game_over_q;
    assign winner        = winner_q;
    assign timeout_err   = timeout_err_q;

endmodule

// File: tb/tb_turn_sequencer.sv
// Randomized turn-level bench for turn_sequencer against a board-race reference model.
module tb_turn_sequencer;

    localparam int X0 = 32;
    localparam int TW = 64;
    localparam int NT = 9;
`ifdef TURN_TIMEOUT_EN
    localparam int TMO_CYC = 100;
`else
    localparam int TMO_CYC = 50_000_000;
`endif

    logic       clk = 1'b0;
    logic       rst_n = 1'b1;
    logic       start = 1'b0;
    logic       roll_req = 1'b0;
    logic       dice_override_en = 1'b0;
    logic [2:0] dice_override = 3'd0;
    logic       turn_done = 1'b0;
    logic [9:0] player1_pos_x, player2_pos_x;
    logic       pos_valid, active_player, busy, game_over, winner, timeout_err;
    logic [2:0] dice_val;

    int n_checks = 0;
    int n_err = 0;
    int cyc = 0;
    int m_tile[2];
    int m_active;

    always #5 clk = ~clk;

    // Edges seen since reset release; equals the number of LFSR steps taken.
    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) cyc <= 0;
        else        cyc <= cyc + 1;
    end

    turn_sequencer #(.TIMEOUT_CYC(TMO_CYC)) dut (
        .clk              (clk),
        .rst_n            (rst_n),
        .start            (start),
        .roll_req         (roll_req),
        .dice_override_en (dice_override_en),
        .dice_override    (dice_override),
        .turn_done        (turn_done),
        .player1_pos_x    (player1_pos_x),
        .player2_pos_x    (player2_pos_x),
        .pos_valid        (pos_valid),
        .active_player    (active_player),
        .dice_val         (dice_val),
        .busy             (busy),
        .game_over        (game_over),
        .winner           (winner),
        .timeout_err      (timeout_err)
    );

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %0d expected %0d", tag, got, exp);
        end
    endtask

    function automatic int die_after(input int n);
        logic [7:0] s;
        logic [2:0] v;
        s = 8'hA5;
        for (int i = 0; i < n; i++) s = {s[6:0], s[7] ^ s[5] ^ s[4] ^ s[3]};
        v = s[2:0];
        return (v < 3'd6) ? int'(v) + 1 : int'(v) - 5;
    endfunction

    function automatic int exp_x(input int t);
        return X0 + t * TW;
    endfunction

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic watch(input int n, output int pv);
        pv = 0;
        repeat (n) begin
            step();
            if (pos_valid) pv++;
        end
    endtask

    task automatic check_reset();
        chk("rst_p1x", player1_pos_x, X0);
        chk("rst_p2x", player2_pos_x, X0);
        chk("rst_pv", pos_valid, 0);
        chk("rst_act", active_player, 0);
        chk("rst_dice", dice_val, 0);
        chk("rst_busy", busy, 0);
        chk("rst_over", game_over, 0);
        chk("rst_win", winner, 0);
        chk("rst_tmo", timeout_err, 0);
    endtask

    task automatic new_game_model();
        m_tile[0] = 0;
        m_tile[1] = 0;
        m_active = 0;
    endtask

    task automatic do_turn(input bit use_ov, input int ov, input bit stray_issue,
                           input bit stray_wait, input int td_delay, output bit won);
        int p, die, nt, first, pulses;
        p = m_active;
        dice_override_en = use_ov;
        dice_override = ov[2:0];
        roll_req = 1'b1;
        step();
        roll_req = 1'b0;
        die = use_ov ? ((ov == 0 || ov == 7) ? 1 : ov) : die_after(cyc);
        nt = m_tile[p] + die;
        if (nt > NT - 1) nt = NT - 1;
        m_tile[p] = nt;
        chk("roll_busy", busy, 1);
        first = -1;
        pulses = 0;
        for (int t = 1; t <= 6; t++) begin
            step();
            turn_done = 1'b0;
            roll_req = 1'b0;
            if (pos_valid) begin
                pulses++;
                if (first < 0) first = t;
            end
            if (t == 1) begin
                chk("issue_p1x", player1_pos_x, exp_x(m_tile[0]));
                chk("issue_p2x", player2_pos_x, exp_x(m_tile[1]));
                chk("issue_dice", dice_val, die);
                chk("issue_act", active_player, p);
                turn_done = stray_issue;
            end
            if (t == 3) roll_req = stray_wait;
        end
        dice_override_en = 1'b0;
        chk("pv_pulses", pulses, 1);
        chk("pv_latency", first, 1);
        chk("wait_busy", busy, 1);
        chk("wait_act", active_player, p);
        chk("wait_p1x", player1_pos_x, exp_x(m_tile[0]));
        chk("wait_p2x", player2_pos_x, exp_x(m_tile[1]));
        repeat (td_delay) step();
        turn_done = 1'b1;
        step();
        turn_done = 1'b0;
        chk("check_busy", busy, 1);
        chk("check_act", active_player, p);
        step();
        won = (nt == NT - 1);
        if (won) begin
            chk("over_flag", game_over, 1);
            chk("over_winner", winner, p);
            chk("over_busy", busy, 0);
        end else begin
            m_active = 1 - p;
            chk("next_act", active_player, m_active);
            chk("next_busy", busy, 0);
            chk("next_over", game_over, 0);
        end
    endtask

    task automatic restart_game();
        start = 1'b1;
        step();
        start = 1'b0;
        new_game_model();
        chk("restart_pv", pos_valid, 1);
        chk("restart_p1x", player1_pos_x, X0);
        chk("restart_p2x", player2_pos_x, X0);
        chk("restart_act", active_player, 0);
        chk("restart_over", game_over, 0);
    endtask

    initial begin
        bit won;
        int pv;
        #2 rst_n = 1'b0;
        repeat (3) @(posedge clk);
        #3 rst_n = 1'b1;
        step();
        check_reset();

        // Roll before any start must be ignored.
        roll_req = 1'b1;
        step();
        roll_req = 1'b0;
        watch(4, pv);
        chk("idle_roll_pv", pv, 0);
        chk("idle_roll_busy", busy, 0);

        // start and roll_req together: only start takes effect.
        start = 1'b1;
        roll_req = 1'b1;
        step();
        start = 1'b0;
        roll_req = 1'b0;
        watch(3, pv);
        chk("start_roll_pv", pv, 0);
        chk("start_roll_busy", busy, 0);
        new_game_model();

        turn_done = 1'b1;
        step();
        turn_done = 1'b0;
        watch(2, pv);
        chk("ready_td_pv", pv, 0);
        chk("ready_td_act", active_player, 0);

        // Directed game: P1 3, P2 6, P1 +4, P2 coerced 1, P1 +5 clamps onto the flag.
        do_turn(1'b1, 3, 1'b1, 1'b1, 2, won);
        chk("t2_p1x", player1_pos_x, 224);
        do_turn(1'b1, 6, 1'b0, 1'b0, 0, won);
        chk("t3_p2x", player2_pos_x, 416);
        chk("t3_p1x_held", player1_pos_x, 224);
        do_turn(1'b1, 4, 1'b0, 1'b1, 1, won);
        do_turn(1'b1, 0, 1'b1, 1'b0, 3, won);
        chk("t5_dice_coerced", dice_val, 1);
        do_turn(1'b1, 5, 1'b0, 1'b0, 0, won);
        chk("t4_won", won, 1);
        chk("t4_p1x_clamp", player1_pos_x, 544);

        roll_req = 1'b1;
        step();
        roll_req = 1'b0;
        watch(4, pv);
        chk("over_roll_pv", pv, 0);
        chk("over_hold", game_over, 1);
        chk("over_winner_hold", winner, 0);
        restart_game();
        step();
        chk("restart_pv_end", pos_valid, 0);

        for (int g = 0; g < 40; g++) begin
            do_turn(1'($urandom_range(0, 1)), int'($urandom_range(0, 7)), 1'($urandom_range(0, 1)),
                    1'($urandom_range(0, 1)), int'($urandom_range(0, 5)), won);
            if (won) restart_game();
        end

`ifdef TURN_TIMEOUT_EN
        begin
            int p, first, nt;
            bit done;
            p = m_active;
            dice_override_en = 1'b1;
            dice_override = 3'd1;
            roll_req = 1'b1;
            step();
            roll_req = 1'b0;
            nt = m_tile[p] + 1;
            if (nt > NT - 1) nt = NT - 1;
            m_tile[p] = nt;
            first = -1;
            done = 1'b0;
            for (int t = 1; t <= 200 && !done; t++) begin
                step();
                if (timeout_err && first < 0) first = t;
                if (active_player != p || game_over) done = 1'b1;
            end
            dice_override_en = 1'b0;
            chk("tmo_flag", timeout_err, 1);
            chk("tmo_cycle", first, 102);
            chk("tmo_done", done, 1);
            won = (nt == NT - 1);
            if (won) chk("tmo_over", game_over, 1);
            else begin
                m_active = 1 - p;
                chk("tmo_toggle", active_player, m_active);
            end
            for (int k = 0; k < 6 && !won; k++) do_turn(1'b1, 6, 1'b0, 1'b0, 0, won);
            restart_game();
            chk("tmo_sticky", timeout_err, 1);
        end
`else
        chk("tmo_tied", timeout_err, 0);
`endif

        // Reset asserted in the middle of WAIT.
        roll_req = 1'b1;
        step();
        roll_req = 1'b0;
        repeat (3) step();
        chk("mid_wait_busy", busy, 1);
        #2 rst_n = 1'b0;
        #1;
        check_reset();
        @(posedge clk);
        #3 rst_n = 1'b1;
        step();
        check_reset();
        roll_req = 1'b1;
        step();
        roll_req = 1'b0;
        watch(4, pv);
        chk("post_rst_roll_pv", pv, 0);
        chk("post_rst_busy", busy, 0);

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_err);
        $finish;
    end

endmodule
